// File: rtl/accfifo_ctrl_pkg.sv
// Shared constants for the accumulation FIFO swap controller.
//   StIdle / StDrain : FSM state encodings
//   RdLatMax         : largest supported FIFO read-to-data latency
//   cnt_w()          : width of a counter that must hold 0..depth inclusive
package accfifo_ctrl_pkg;

    localparam logic StIdle  = 1'b0;
    localparam logic StDrain = 1'b1;

    localparam int unsigned RdLatMax = 2;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gb_skid_buf.sv
// Two-entry output buffer holding data words and their last-of-tile flag.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data,
//   push_last         write one entry (caller guarantees there is room)
//   pop               remove the head entry (caller guarantees valid)
//   valid             buffer holds at least one entry
//   count             number of entries held (0..2)
//   data, last        head entry
module gb_skid_buf #(
    parameter int unsigned DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic          valid,
    output logic [1:0]    count,
    output logic [DW-1:0] data,
    output logic          last
);

    logic [DW-1:0] mem_q [2];
    logic [1:0]    last_q;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]  <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;
    assign data  = mem_q[rd_ptr_q];
    assign last  = last_q[rd_ptr_q];

endmodule

// File: rtl/accfifo_swap_ctrl.sv
// Sequencer for one double-buffered accumulation FIFO pair. Counts tile writes into the compute
// FIFO, swaps compute/shadow roles when a tile completes, drains the shadow FIFO to the global
// buffer over valid/ready and stalls the PE while a completed tile waits for the drain to finish.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   compute_fifo_write       snooped PE write strobe into the compute FIFO
//   tile_done                compute FIFO holds a complete tile
//   shadow_fifo_empty        shadow FIFO status
//   shadow_fifo_data_out     shadow FIFO read data (RD_LAT cycles after the read strobe)
//   which_fifo_to_compute    role select (0: FIFO0 computes)
//   shadow_fifo_read         shadow FIFO read strobe
//   compute_stall            PE must hold writes and tile_done
//   gb_valid/gb_data/gb_last output word to the global buffer, gb_ready accepts it
//   busy                     drain in progress or swap pending
//   err                      sticky protocol error
module accfifo_swap_ctrl
    import accfifo_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned OUT_WIDTH = 24,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 compute_fifo_write,
    input  logic                 tile_done,
    input  logic                 shadow_fifo_empty,
    input  logic [OUT_WIDTH-1:0] shadow_fifo_data_out,
    output logic                 which_fifo_to_compute,
    output logic                 shadow_fifo_read,
    output logic                 compute_stall,
    output logic                 gb_valid,
    output logic [OUT_WIDTH-1:0] gb_data,
    output logic                 gb_last,
    input  logic                 gb_ready,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned     CntW   = cnt_w(NB_DATA);
    localparam int unsigned     Lat    = (RD_LAT > RdLatMax) ? RdLatMax : RD_LAT;
    localparam logic [CntW-1:0] CntMax = CntW'(NB_DATA);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic            state_q, state_d;
    logic            which_q, which_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0] rem_rd_q, rem_rd_d;
    logic [CntW-1:0] rem_out_q, rem_out_d;

    logic            wr_ok, wr_err, td_err, swap, drain;
    logic [CntW-1:0] cnt_eff;
    logic            rd, rd_last, pop;
    logic            push, push_last;
    logic [1:0]      buf_cnt, inflight;
    logic [2:0]      occ;
    logic            buf_valid, buf_last;

    // Writes are refused while stalled or once the tile already fills the FIFO.
    assign wr_ok   = compute_fifo_write & ~pend_q & (wr_cnt_q != CntMax);
    assign wr_err  = compute_fifo_write & ~wr_ok;
    assign td_err  = tile_done & pend_q;
    // A write in the swap cycle still belongs to the closing tile.
    assign cnt_eff = wr_cnt_q + CntW'(wr_ok);
    assign drain   = (state_q == StDrain);
    assign swap    = ~drain & (tile_done | pend_q) & (cnt_eff != '0);

    assign pop = buf_valid & gb_ready;
    // Reads in flight plus buffered words may never exceed the two buffer slots; a word leaving
    // this cycle frees its slot early so RD_LAT <= 1 sustains one word per cycle.
    assign occ     = {1'b0, buf_cnt} + {1'b0, inflight};
    assign rd      = drain & (rem_rd_q != '0) & ~shadow_fifo_empty & (occ < (3'd2 + {2'b0, pop}));
    assign rd_last = (rem_rd_q == CntOne);

    always_comb begin
        state_d   = state_q;
        which_d   = which_q;
        pend_d    = pend_q;
        err_d     = err_q | wr_err | td_err;
        wr_cnt_d  = cnt_eff;
        rem_rd_d  = rem_rd_q - CntW'(rd);
        rem_out_d = rem_out_q - CntW'(pop);
        if (swap) begin
            state_d   = StDrain;
            which_d   = ~which_q;
            pend_d    = 1'b0;
            wr_cnt_d  = '0;
            rem_rd_d  = cnt_eff;
            rem_out_d = cnt_eff;
        end
        if (drain) begin
            // An empty tile never becomes pending, so pend always leads to a real swap.
            if (tile_done & ~pend_q & (cnt_eff != '0)) begin
                pend_d = 1'b1;
            end
            if (pop & (rem_out_q == CntOne)) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            which_q   <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
            rem_rd_q  <= '0;
            rem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            which_q   <= which_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            wr_cnt_q  <= wr_cnt_d;
            rem_rd_q  <= rem_rd_d;
            rem_out_q <= rem_out_d;
        end
    end

    // Track each read (and whether it is the tile's final word) until its data appears.
    generate
        if (Lat == 0) begin : g_rd_comb
            assign push      = rd;
            assign push_last = rd_last;
            assign inflight  = 2'd0;
        end else begin : g_rd_pipe
            logic [Lat-1:0] rd_pipe_q;
            logic [Lat-1:0] last_pipe_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_pipe_q   <= '0;
                    last_pipe_q <= '0;
                end else begin
                    rd_pipe_q   <= (rd_pipe_q << 1) | Lat'(rd);
                    last_pipe_q <= (last_pipe_q << 1) | Lat'(rd & rd_last);
                end
            end

            always_comb begin
                inflight = 2'd0;
                for (int i = 0; i < Lat; i++) begin
                    inflight = inflight + {1'b0, rd_pipe_q[i]};
                end
            end

            assign push      = rd_pipe_q[Lat-1];
            assign push_last = last_pipe_q[Lat-1];
        end
    endgenerate

    gb_skid_buf #(
        .DW(OUT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shadow_fifo_data_out),
        .push_last (push_last),
        .pop       (pop),
        .valid     (buf_valid),
        .count     (buf_cnt),
        .data      (gb_data),
        .last      (buf_last)
    );

    assign which_fifo_to_compute = which_q;
    assign shadow_fifo_read      = rd;
    assign compute_stall         = pend_q;
    assign gb_valid              = buf_valid;
    assign gb_last               = buf_valid & buf_last;
    assign busy                  = drain | pend_q;
    assign err                   = err_q;

endmodule

// File: tb/tb_accfifo_swap_ctrl.sv
// Bench: three controllers (RD_LAT 0, 1, 2) share one stimulus stream, each beside its own
// behavioural FIFO pair. A tile-level reference model pushes expected words into a shared list;
// per-instance monitors pop and compare whenever a word is transferred.
module tb_accfifo_swap_ctrl;

    localparam int NI = 3;
    localparam int W  = 24;
    localparam int NB = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr  = 1'b0;
    logic td  = 1'b0;
    logic rdy = 1'b0;
    logic [W-1:0] wdata = '0;

    logic         empty_s [NI];
    logic [W-1:0] fdata_s [NI];
    logic         which_s [NI];
    logic         sfr_s   [NI];
    logic         stall_s [NI];
    logic         valid_s [NI];
    logic [W-1:0] gdata_s [NI];
    logic         last_s  [NI];
    logic         busy_s  [NI];
    logic         err_s   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0]   exp_all[$];   // {last, data} in required output order
    logic [W-1:0] cur_tile[$];  // accepted words of the tile being written
    int   idx_a[NI];            // next expected word per instance
    int   out_a[NI];            // reads issued but not yet transferred
    logic ref_which = 1'b0;
    logic ref_err   = 1'b0;
    int   rdy_mode  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [W-1:0] q0[$];
        logic [W-1:0] q1[$];
        logic [W-1:0] head0 = '0;
        logic [W-1:0] head1 = '0;
        logic [W-1:0] dout  = '0;
        logic [W-1:0] pipe  = '0;
        logic [W-1:0] popped;
        logic         empty0 = 1'b1;
        logic         empty1 = 1'b1;
        logic         hold_pend = 1'b0;
        logic [W-1:0] held = '0;

        assign empty_s[g] = which_s[g] ? empty0 : empty1;
        assign fdata_s[g] = (g == 0) ? (which_s[g] ? head0 : head1) : dout;

        accfifo_swap_ctrl #(
            .NB_DATA   (NB),
            .OUT_WIDTH (W),
            .RD_LAT    (g)
        ) u_dut (
            .clk                   (clk),
            .rst                   (rst),
            .compute_fifo_write    (wr),
            .tile_done             (td),
            .shadow_fifo_empty     (empty_s[g]),
            .shadow_fifo_data_out  (fdata_s[g]),
            .which_fifo_to_compute (which_s[g]),
            .shadow_fifo_read      (sfr_s[g]),
            .compute_stall         (stall_s[g]),
            .gb_valid              (valid_s[g]),
            .gb_data               (gdata_s[g]),
            .gb_last               (last_s[g]),
            .gb_ready              (rdy),
            .busy                  (busy_s[g]),
            .err                   (err_s[g])
        );

        // FIFO pair model: compute FIFO = which, shadow FIFO = the other one.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q0.delete();
                q1.delete();
                head0  <= '0;
                head1  <= '0;
                empty0 <= 1'b1;
                empty1 <= 1'b1;
                dout   <= '0;
                pipe   <= '0;
                out_a[g] = 0;
            end else begin
                popped = '0;
                if (wr) begin
                    if (!which_s[g]) begin
                        if (q0.size() < NB) q0.push_back(wdata);
                    end else begin
                        if (q1.size() < NB) q1.push_back(wdata);
                    end
                end
                if (valid_s[g] && rdy) out_a[g]--;
                if (sfr_s[g]) begin
                    if (which_s[g] ? (q0.size() == 0) : (q1.size() == 0))
                        check($sformatf("lat%0d read on empty", g), 1, 0);
                    else
                        popped = which_s[g] ? q0.pop_front() : q1.pop_front();
                    out_a[g]++;
                    check($sformatf("lat%0d outstanding<=2", g), out_a[g] <= 2, 1);
                end
                pipe   <= popped;
                dout   <= (g == 1) ? popped : pipe;
                head0  <= (q0.size() > 0) ? q0[0] : '0;
                head1  <= (q1.size() > 0) ? q1[0] : '0;
                empty0 <= (q0.size() == 0);
                empty1 <= (q1.size() == 0);
            end
        end

        // Monitor: compare every transferred word, check held words stay stable.
        always @(negedge clk) begin
            if (rst) begin
                idx_a[g] = exp_all.size();
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check($sformatf("lat%0d hold valid", g), valid_s[g], 1);
                    check($sformatf("lat%0d hold data", g), gdata_s[g], held);
                end
                if (valid_s[g]) begin
                    if (rdy) begin
                        if (idx_a[g] >= exp_all.size()) begin
                            check($sformatf("lat%0d extra word", g), 1, 0);
                        end else begin
                            check($sformatf("lat%0d data #%0d", g, idx_a[g]), gdata_s[g],
                                  exp_all[idx_a[g]][W-1:0]);
                            check($sformatf("lat%0d last #%0d", g, idx_a[g]), last_s[g],
                                  exp_all[idx_a[g]][W]);
                            idx_a[g]++;
                        end
                    end
                    hold_pend = !rdy;
                    held      = gdata_s[g];
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = ~rdy;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_write(input logic [W-1:0] d);
        if (cur_tile.size() < NB) cur_tile.push_back(d);
        else ref_err = 1'b1;
    endtask

    task automatic ref_close();
        if (cur_tile.size() > 0) begin
            for (int k = 0; k < cur_tile.size(); k++)
                exp_all.push_back({k == cur_tile.size() - 1, cur_tile[k]});
            cur_tile.delete();
            ref_which = ~ref_which;
        end
    endtask

    task automatic ref_reset();
        cur_tile.delete();
        ref_which = 1'b0;
        ref_err   = 1'b0;
    endtask

    task automatic write_words(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                wr = 1'b0;
                tick();
            end
            wr    = 1'b1;
            wdata = W'($urandom);
            ref_write(wdata);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic close_tile(input bit with_write);
        td = 1'b1;
        if (with_write) begin
            wr    = 1'b1;
            wdata = W'($urandom);
            ref_write(wdata);
        end
        ref_close();
        tick();
        td = 1'b0;
        wr = 1'b0;
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s lat%0d ctl outputs", name, i),
                  {which_s[i], sfr_s[i], stall_s[i], valid_s[i], last_s[i], busy_s[i], err_s[i]},
                  0);
            check($sformatf("%s lat%0d gb_data", name, i), gdata_s[i], 0);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        bit done = 1'b0;
        while (!done && t < 1000) begin
            tick();
            t++;
            done = 1'b1;
            for (int i = 0; i < NI; i++) if (busy_s[i] || valid_s[i]) done = 1'b0;
        end
        check({name, " idle in time"}, done, 1);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s lat%0d words drained", name, i), idx_a[i], exp_all.size());
            check($sformatf("%s lat%0d which", name, i), which_s[i], ref_which);
            check($sformatf("%s lat%0d err", name, i), err_s[i], ref_err);
        end
    endtask

    task automatic wait_unstall(input string name);
        int t = 0;
        bit done = 1'b0;
        while (!done && t < 1000) begin
            tick();
            t++;
            done = 1'b1;
            for (int i = 0; i < NI; i++) if (stall_s[i]) done = 1'b0;
        end
        check({name, " stall released"}, done, 1);
    endtask

    initial begin
        #2;
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Basic tile of 5 with gb_ready held high.
        rdy_mode = 0;
        write_words(5, 1'b0);
        for (int i = 0; i < NI; i++) check($sformatf("A lat%0d which pre", i), which_s[i], ref_which);
        close_tile(1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("A lat%0d which toggled", i), which_s[i], ref_which);
            check($sformatf("A lat%0d busy", i), busy_s[i], 1);
        end
        wait_idle("A");

        // Drain of 8 with gb_ready toggling.
        rdy_mode = 1;
        write_words(8, 1'b0);
        close_tile(1'b0);
        wait_idle("B");

        // Empty tile_done ignored; then write + tile_done together at count 3.
        rdy_mode = 0;
        close_tile(1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("D lat%0d empty td which", i), which_s[i], ref_which);
            check($sformatf("D lat%0d empty td busy", i), busy_s[i], 0);
        end
        write_words(3, 1'b0);
        close_tile(1'b1);
        wait_idle("D");

        // tile_done mid-drain stalls the PE; a second one while pending is an error.
        write_words(6, 1'b0);
        close_tile(1'b0);
        write_words(3, 1'b0);
        close_tile(1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("C lat%0d stall", i), stall_s[i], 1);
            check($sformatf("C lat%0d busy", i), busy_s[i], 1);
        end
        td = 1'b1;
        ref_err = 1'b1;
        tick();
        td = 1'b0;
        for (int i = 0; i < NI; i++) check($sformatf("C lat%0d err", i), err_s[i], 1);
        wait_unstall("C");
        wait_idle("C");

        rst = 1'b1;
        tick();
        check_zero("reset2");
        rst = 1'b0;
        ref_reset();
        tick();

        // Overfill: the 33rd write is an error and is not counted.
        rdy_mode = 2;
        write_words(33, 1'b0);
        for (int i = 0; i < NI; i++) check($sformatf("E lat%0d err", i), err_s[i], 1);
        close_tile(1'b0);
        wait_idle("E");

        // Reset in the middle of a drain, then a fresh tile.
        rdy_mode = 1;
        write_words(10, 1'b0);
        close_tile(1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_zero("rst mid-drain");
        tick();
        rst = 1'b0;
        ref_reset();
        tick();
        write_words(7, 1'b0);
        close_tile(1'b0);
        wait_idle("F");

        // Randomized tiles.
        for (int it = 0; it < 8; it++) begin
            rdy_mode = $urandom_range(0, 2);
            write_words($urandom_range(1, 31), 1'b1);
            close_tile(1'($urandom_range(0, 1)));
            wait_idle($sformatf("G%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
